nx_ram_hw_port_arb: RTL and testbench

Round-robin arbiter that shares the single hardware port of an indirect-access single-port RAM among N_REQ hardware requesters. It registers the winning command onto the RAM hw port and returns read data to the issuing requester after a fixed latency. It honours the RAM's software-yield request by inserting idle hw cycles, so register-bus indirect accesses are never starved.

---
 rtl/nx_ram_hw_port_arb.sv | 170 +++++++++++++++++
 tb/tb_nx_ram_hw_port_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_ram_hw_port_arb.sv
// nx_ram_hw_port_arb
// Round-robin arbiter that shares the hardware port of an indirect-access
// single-port RAM among N_REQ requesters. The winning command is registered
// onto the hw_* outputs. Read data returns to the issuing requester after
// RD_LATENCY cycles, with no backpressure on the response path. When the RAM
// raises hw_yield and a full burst has already gone out, one idle hw cycle is
// inserted so that software accesses can reach the RAM.
//
// Handshake: requester i's command is taken in any cycle where
// req_valid_i[i] && req_ready_o[i]. req_ready_o is one-hot or zero and is a
// combinational function of req_valid_i, rr_ptr, hw_yield_i and burst_cnt.
// A requester may change its command only after it has been taken.
// rsp_valid_o is a one-hot strobe that qualifies rsp_dat_o, and it must be
// sunk unconditionally.
module nx_ram_hw_port_arb #(
    parameter int N_REQ       = 4,
    parameter int N_ENTRIES   = 1024,
    parameter int N_DATA_BITS = 32,
    parameter int RD_LATENCY  = 1,
    parameter int MAX_BURST   = 8,
    localparam int AW = $clog2(N_ENTRIES),
    localparam int DW = N_DATA_BITS,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [N_REQ-1:0]      req_we_i,
    input  logic [N_REQ*AW-1:0]   req_addr_i,
    input  logic [N_REQ*DW-1:0]   req_din_i,
    input  logic [N_REQ*DW-1:0]   req_bwe_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic [N_REQ-1:0]      rsp_valid_o,
    output logic [DW-1:0]         rsp_dat_o,
    output logic                  hw_cs_o,
    output logic                  hw_we_o,
    output logic [AW-1:0]         hw_add_o,
    output logic [DW-1:0]         hw_din_o,
    output logic [DW-1:0]         hw_bwe_o,
    input  logic [DW-1:0]         hw_dout_i,
    input  logic                  hw_yield_i,
    output logic [PW-1:0]         dbg_rr_ptr_o,
    output logic [7:0]            dbg_burst_cnt_o
);

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [PW-1:0]    scan_idx [N_REQ];
    logic             found;
    logic [PW-1:0]    gnt_idx;
    logic             blocked;
    logic             accept;
    logic [N_REQ-1:0] gnt_oh;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_din;
    logic [DW-1:0]    sel_bwe;
    logic             hw_cs_q;
    logic             hw_we_q;
    logic [AW-1:0]    hw_add_q;
    logic [DW-1:0]    hw_din_q;
    logic [DW-1:0]    hw_bwe_q;
    logic [N_REQ-1:0] hw_id_q;
    logic [N_REQ-1:0] tag_q [RD_LATENCY];

    // Search order: requester indices starting at rr_ptr, wrapping modulo N_REQ
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx[k] = PW'((int'(rr_ptr_q) + k) % N_REQ);
        end
    end

    // Pick the first valid requester in search order, unless the cycle is blocked by a yield
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid_i[scan_idx[k]]) begin
                found   = 1'b1;
                gnt_idx = scan_idx[k];
            end
        end
        blocked = hw_yield_i && (burst_cnt_q == 8'(MAX_BURST));
        // No grants while reset is asserted, so req_ready reads zero in reset
        accept  = found && !blocked && rst_n;
        gnt_oh  = accept ? (N_REQ'(1) << gnt_idx) : '0;
    end

    // Mux the granted requester's command fields
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        sel_bwe  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_we   = req_we_i[i];
                sel_addr = req_addr_i[i*AW +: AW];
                sel_din  = req_din_i[i*DW +: DW];
                sel_bwe  = req_bwe_i[i*DW +: DW];
            end
        end
    end

    // Pointer advances past the winner; burst count tracks consecutive hw_cs cycles including the next one
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = '0;
        if (accept) begin
            rr_ptr_d    = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
            burst_cnt_d = (burst_cnt_q == 8'(MAX_BURST)) ? burst_cnt_q : burst_cnt_q + 8'd1;
        end
    end

    // Arbiter state, chip select and the one-hot id of the command now on the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            hw_cs_q     <= 1'b0;
            hw_id_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            hw_cs_q     <= accept;
            hw_id_q     <= gnt_oh;
        end
    end

    // Command fields load only on accept and otherwise hold their last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_we_q  <= 1'b0;
            hw_add_q <= '0;
            hw_din_q <= '0;
            hw_bwe_q <= '0;
        end else if (accept) begin
            hw_we_q  <= sel_we;
            hw_add_q <= sel_addr;
            hw_din_q <= sel_din;
            hw_bwe_q <= sel_bwe;
        end
    end

    // Read tag pipeline: a zero entry means that no read occupies that slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= (hw_cs_q && !hw_we_q) ? hw_id_q : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign req_ready_o     = gnt_oh;
    assign rsp_valid_o     = tag_q[RD_LATENCY-1];
    assign rsp_dat_o       = hw_dout_i;
    assign hw_cs_o         = hw_cs_q;
    assign hw_we_o         = hw_we_q;
    assign hw_add_o        = hw_add_q;
    assign hw_din_o        = hw_din_q;
    assign hw_bwe_o        = hw_bwe_q;
    assign dbg_rr_ptr_o    = rr_ptr_q;
    assign dbg_burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_nx_ram_hw_port_arb.sv
// Bench for nx_ram_hw_port_arb: two instances (RD_LATENCY 1 and 3) share the
// same request stimulus, and each one drives its own behavioural RAM.
module tb_nx_ram_hw_port_arb;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int W  = 68;   // {due cycle[31:0], id[3:0], data[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din, req_bwe;
    logic            hw_yield;

    logic [N-1:0]  rdy1, rdy3, rspv1, rspv3;
    logic [DW-1:0] rspd1, rspd3, din1, din3, bwe1, bwe3, dout1, dout3;
    logic          cs1, cs3, we1, we3;
    logic [AW-1:0] add1, add3;
    logic [1:0]    ptr1, ptr3;
    logic [7:0]    bc1, bc3;

    nx_ram_hw_port_arb #(.N_REQ(N), .N_ENTRIES(1024), .N_DATA_BITS(DW), .RD_LATENCY(1), .MAX_BURST(MB)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_din_i(req_din), .req_bwe_i(req_bwe), .req_ready_o(rdy1), .rsp_valid_o(rspv1), .rsp_dat_o(rspd1),
        .hw_cs_o(cs1), .hw_we_o(we1), .hw_add_o(add1), .hw_din_o(din1), .hw_bwe_o(bwe1),
        .hw_dout_i(dout1), .hw_yield_i(hw_yield), .dbg_rr_ptr_o(ptr1), .dbg_burst_cnt_o(bc1)
    );

    nx_ram_hw_port_arb #(.N_REQ(N), .N_ENTRIES(1024), .N_DATA_BITS(DW), .RD_LATENCY(3), .MAX_BURST(MB)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_din_i(req_din), .req_bwe_i(req_bwe), .req_ready_o(rdy3), .rsp_valid_o(rspv3), .rsp_dat_o(rspd3),
        .hw_cs_o(cs3), .hw_we_o(we3), .hw_add_o(add3), .hw_din_o(din3), .hw_bwe_o(bwe3),
        .hw_dout_i(dout3), .hw_yield_i(hw_yield), .dbg_rr_ptr_o(ptr3), .dbg_burst_cnt_o(bc3)
    );

    // ---------------- RAM models ----------------
    logic [DW-1:0] mem1 [1024];
    logic [DW-1:0] mem3 [1024];
    logic [DW-1:0] rp1 [1];
    logic [DW-1:0] rp3 [3];

    always @(posedge clk) begin
        if (cs1) begin
            if (we1) mem1[add1] <= (mem1[add1] & ~bwe1) | (din1 & bwe1);
            else     rp1[0] <= mem1[add1];
        end
    end

    always @(posedge clk) begin
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
        if (cs3) begin
            if (we3) mem3[add3] <= (mem3[add3] & ~bwe3) | (din3 & bwe3);
            else     rp3[0] <= mem3[add3];
        end
    end

    assign dout1 = rp1[0];
    assign dout3 = rp3[2];

    function automatic logic [DW-1:0] pat(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0]  exp_q1 [$];
    logic [W-1:0]  exp_q3 [$];
    logic [DW-1:0] exp_mem [1024];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            m_ptr = 0;
    int            m_burst = 0;
    logic          m_cs = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_add = '0;
    logic [DW-1:0] m_din = '0;
    logic [DW-1:0] m_bwe = '0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check at negedge, advance the model, and return at posedge+1 for driving
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        logic [W-1:0] e;
        int g;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            chk("reset_l1", 96'({rdy1, rspv1, cs1, we1, add1, din1, bwe1, ptr1, bc1}), 96'(0));
            chk("reset_l3", 96'({rdy3, rspv3, cs3, we3, add3, din3, bwe3, ptr3, bc3}), 96'(0));
            m_ptr = 0; m_burst = 0; m_cs = 0; m_we = 0; m_add = '0; m_din = '0; m_bwe = '0;
            exp_q1.delete();
            exp_q3.delete();
        end else begin
            if (exp_q1.size() > 0 && exp_q1[0][67:36] == 32'(cyc)) begin
                e = exp_q1.pop_front();
                chk("rsp_l1", 96'({rspv1, rspd1}), 96'({e[35:32], e[31:0]}));
            end else begin
                chk("rsp_idle_l1", 96'(rspv1), 96'(0));
            end
            if (exp_q3.size() > 0 && exp_q3[0][67:36] == 32'(cyc)) begin
                e = exp_q3.pop_front();
                chk("rsp_l3", 96'({rspv3, rspd3}), 96'({e[35:32], e[31:0]}));
            end else begin
                chk("rsp_idle_l3", 96'(rspv3), 96'(0));
            end
            chk("hw_l1", 96'({cs1, we1, add1, din1, bwe1}), 96'({m_cs, m_we, m_add, m_din, m_bwe}));
            chk("hw_l3", 96'({cs3, we3, add3, din3, bwe3}), 96'({m_cs, m_we, m_add, m_din, m_bwe}));
            chk("rr_ptr_l1", 96'(ptr1), 96'(m_ptr));
            exp_rdy = '0;
            g = -1;
            if (!(hw_yield && m_burst == MB)) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("ready_l1", 96'(rdy1), 96'(exp_rdy));
            chk("ready_l3", 96'(rdy3), 96'(exp_rdy));
            if (g >= 0) begin
                m_cs  = 1'b1;
                m_we  = req_we[g];
                m_add = req_addr[g*AW +: AW];
                m_din = req_din[g*DW +: DW];
                m_bwe = req_bwe[g*DW +: DW];
                m_ptr = (g + 1) % N;
                m_burst = (m_burst == MB) ? MB : m_burst + 1;
                if (m_we) begin
                    exp_mem[m_add] = (exp_mem[m_add] & ~m_bwe) | (m_din & m_bwe);
                end else begin
                    exp_q1.push_back({32'(cyc + 2), exp_rdy, exp_mem[m_add]});
                    exp_q3.push_back({32'(cyc + 4), exp_rdy, exp_mem[m_add]});
                end
            end else begin
                m_cs = 1'b0;
                m_burst = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] b);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_din[i*DW +: DW]  = d;
        req_bwe[i*DW +: DW]  = b;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_din = '0; req_bwe = '0; hw_yield = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = pat(i);
            mem3[i] = pat(i);
            exp_mem[i] = pat(i);
        end
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Single requester read
        set_req(2, 1'b0, 10'h010, '0, '0);
        cycle();
        idle(6);

        // Round-robin with all four held valid after reset
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 10'(10'h100 + i), $urandom, 32'hFFFF_FFFF);
        repeat (8) cycle();
        req_valid = '0;
        chk("rr_ptr_after_8", 96'(ptr1), 96'(0));
        idle(2);

        // Write then read of the same address from another requester
        set_req(1, 1'b1, 10'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        cycle();
        req_valid = '0;
        set_req(3, 1'b0, 10'd5, '0, '0);
        cycle();
        idle(6);
        chk("wr_rd_mem", 96'(mem1[5]), 96'(32'hDEAD_BEEF));

        // Back-to-back reads from 0, 1, 2
        for (int i = 0; i < 3; i++) begin
            req_valid = '0;
            set_req(i, 1'b0, 10'($urandom_range(0, 1023)), '0, '0);
            cycle();
        end
        idle(6);

        // Random mix of requests, reads/writes and yields
        for (int r = 0; r < 60; r++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_we    = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW] = 10'($urandom_range(0, 1023));
                req_din[i*DW +: DW]  = $urandom;
                req_bwe[i*DW +: DW]  = $urandom;
            end
            hw_yield = ($urandom_range(0, 3) == 0);
            cycle();
        end
        hw_yield = 1'b0;
        idle(6);

        // Yield gap: 8 hw_cs cycles, then one idle, repeating
        do_reset();
        hw_yield = 1'b1;
        for (int k = 0; k < 27; k++) begin
            set_req(0, 1'b0, 10'($urandom_range(0, 1023)), '0, '0);
            cycle();
            chk("yield_pattern", 96'(cs1), 96'((k % 9) != 8));
        end
        hw_yield = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_req(0, 1'b0, 10'($urandom_range(0, 1023)), '0, '0);
            cycle();
            chk("no_yield_cs", 96'(cs1), 96'(1));
        end
        hw_yield = 1'b1;
        cycle();
        chk("yield_immediate", 96'(cs1), 96'(0));
        hw_yield = 1'b0;
        idle(6);

        // Reset one cycle after a read is accepted
        set_req(0, 1'b0, 10'h033, '0, '0);
        cycle();
        req_valid = '0;
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        idle(6);

        // First grant after reset goes to requester 0
        set_req(0, 1'b0, 10'h044, '0, '0);
        set_req(3, 1'b0, 10'h055, '0, '0);
        cycle();
        chk("first_grant_after_reset", 96'(cs1 && add1 == 10'h044), 96'(1));
        cycle();
        idle(6);

        chk("queues_drained", 96'(exp_q1.size() + exp_q3.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
